// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode trap CSR file: addresses, op encoding,
// interrupt codes and the mstatus layout.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // Interrupt codes double as the bit positions in mie/mip.
  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LSB  = 11;

  localparam logic [31:0] MIE_WMASK = 32'h0000_0888;
  localparam logic [1:0]  PRIV_U    = 2'b00;
  localparam logic [1:0]  PRIV_M    = 2'b11;

  typedef struct packed {
    logic [18:0] rsv_hi;
    logic [1:0]  mpp;
    logic [2:0]  rsv_mid;
    logic        mpie;
    logic [2:0]  rsv_lo;
    logic        mie;
    logic [2:0]  rsv_base;
  } mstatus_t;

  function automatic logic [31:0] csr_apply_op(input csr_op_e op, input logic [31:0] old_val,
                                               input logic [31:0] wdata);
    logic [31:0] res;
    case (op)
      CSR_OP_WRITE: res = wdata;
      CSR_OP_SET:   res = old_val | wdata;
      CSR_OP_CLEAR: res = old_val & ~wdata;
      default:      res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_mtrap_file_if.sv
// CSR access port between decode/writeback (master) and the CSR file (slave).
interface csr_mtrap_file_if;
  import csr_pkg::*;

  logic [11:0] csr_addr;
  csr_op_e     csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  modport master (output csr_addr, csr_op, csr_wdata, input csr_rdata, csr_illegal);
  modport slave  (input csr_addr, csr_op, csr_wdata, output csr_rdata, csr_illegal);
endinterface

// File: rtl/csr_counter64.sv
// Free-running counter up to 64 bits with independent 32-bit half writes.
module csr_counter64 #(
  parameter int WIDTH = 64
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_next;

  assign count_inc = count_reg + WIDTH'(inc);

  // A written half takes the operand as-is; the low half still advances on a
  // high-half write but its carry is discarded.
  always_comb begin
    count_next = count_inc;
    if (wr_lo) begin
      count_next = {count_reg[WIDTH-1:32], wdata};
    end else if (wr_hi) begin
      count_next = {wdata[WIDTH-33:0], count_inc[31:0]};
    end
  end

  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = 64'(count_reg);

endmodule

// File: rtl/csr_mtrap_file.sv
// Machine-mode CSR file: CSR read/modify/write, cycle/instret counters,
// trap entry, mret and interrupt arbitration.
module csr_mtrap_file
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter int          COUNTER_W   = 64,
  parameter bit          HAS_U       = 1'b1,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic                    ctrl_clk,
  input  logic                    ctrl_reset,
  csr_mtrap_file_if.slave         csr_bus,
  input  logic                    instret_inc,
  input  logic                    trap_valid,
  input  logic [31:0]             trap_cause,
  input  logic [31:0]             trap_epc,
  input  logic [31:0]             trap_tval,
  input  logic [1:0]              cur_priv,
  input  logic                    mret_valid,
  input  logic                    irq_msip,
  input  logic                    irq_mtip,
  input  logic                    irq_meip,
  output logic                    irq_req,
  output logic [31:0]             irq_cause,
  output logic [31:0]             trap_pc,
  output logic [31:0]             mret_pc,
  output logic [1:0]              mret_priv,
  output logic                    ctrl_mie,
  output logic                    ctrl_mpie,
  output logic [1:0]              ctrl_mpp
);

  // Without U-mode MPP can only ever hold M.
  localparam logic [1:0]  MPP_DEFAULT   = HAS_U ? PRIV_U : PRIV_M;
  localparam mstatus_t    MSTATUS_RESET = mstatus_t'({19'b0, MPP_DEFAULT, 11'b0});
  localparam logic [31:0] MISA_VAL      = 32'h4000_0100 | (HAS_U ? 32'h0010_0000 : 32'h0);

  mstatus_t    mstatus_reg;
  logic [31:0] mie_reg, mtvec_reg, mscratch_reg, mepc_reg, mcause_reg, mtval_reg;
  logic [31:0] mip_val, rdata, nv;
  logic        implemented, illegal, csr_we;
  logic [1:0]  cnt_inc, cnt_wr_lo, cnt_wr_hi;
  logic [63:0] cnt_val [2];
  logic [2:0]  irq_pend;
  logic [3:0]  irq_code;

  function automatic logic mpp_legal(input logic [1:0] v);
    return (v == PRIV_M) || (HAS_U && (v == PRIV_U));
  endfunction

  always_comb begin
    mip_val = 32'h0;
    mip_val[IRQ_CODE_MSI] = irq_msip;
    mip_val[IRQ_CODE_MTI] = irq_mtip;
    mip_val[IRQ_CODE_MEI] = irq_meip;
  end

  always_comb begin
    rdata       = 32'h0;
    implemented = 1'b1;
    case (csr_bus.csr_addr)
      CSR_MSTATUS:                 rdata = mstatus_reg;
      CSR_MISA:                    rdata = MISA_VAL;
      CSR_MIE:                     rdata = mie_reg;
      CSR_MTVEC:                   rdata = mtvec_reg;
      CSR_MSCRATCH:                rdata = mscratch_reg;
      CSR_MEPC:                    rdata = mepc_reg;
      CSR_MCAUSE:                  rdata = mcause_reg;
      CSR_MTVAL:                   rdata = mtval_reg;
      CSR_MIP:                     rdata = mip_val;
      CSR_MCYCLE, CSR_CYCLE:       rdata = cnt_val[0][31:0];
      CSR_MCYCLEH, CSR_CYCLEH:     rdata = cnt_val[0][63:32];
      CSR_MINSTRET, CSR_INSTRET:   rdata = cnt_val[1][31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata = cnt_val[1][63:32];
      CSR_MHARTID:                 rdata = HART_ID;
      default:                     implemented = 1'b0;
    endcase
  end

  assign illegal = (csr_bus.csr_op != CSR_OP_NONE) &&
                   (!implemented || (csr_bus.csr_addr[11:10] == 2'b11));
  // Trap and mret in the same cycle swallow any CSR write.
  assign csr_we  = (csr_bus.csr_op != CSR_OP_NONE) && !illegal && !trap_valid && !mret_valid;
  assign nv      = csr_apply_op(csr_bus.csr_op, rdata, csr_bus.csr_wdata);

  assign csr_bus.csr_rdata   = rdata;
  assign csr_bus.csr_illegal = illegal;

  assign cnt_inc   = {instret_inc, 1'b1};
  assign cnt_wr_lo = {csr_we && (csr_bus.csr_addr == CSR_MINSTRET),
                      csr_we && (csr_bus.csr_addr == CSR_MCYCLE)};
  assign cnt_wr_hi = {csr_we && (csr_bus.csr_addr == CSR_MINSTRETH),
                      csr_we && (csr_bus.csr_addr == CSR_MCYCLEH)};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_counter
      csr_counter64 #(.WIDTH(COUNTER_W)) u_counter (
        .ctrl_clk   (ctrl_clk),
        .ctrl_reset (ctrl_reset),
        .inc        (cnt_inc[gi]),
        .wr_lo      (cnt_wr_lo[gi]),
        .wr_hi      (cnt_wr_hi[gi]),
        .wdata      (csr_bus.csr_wdata),
        .count      (cnt_val[gi])
      );
    end
  endgenerate

  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      mstatus_reg  <= MSTATUS_RESET;
      mie_reg      <= 32'h0;
      mtvec_reg    <= MTVEC_RESET;
      mscratch_reg <= 32'h0;
      mepc_reg     <= 32'h0;
      mcause_reg   <= 32'h0;
      mtval_reg    <= 32'h0;
    end else if (trap_valid) begin
      mepc_reg         <= trap_epc & ~32'h3;
      mcause_reg       <= trap_cause;
      mtval_reg        <= trap_tval;
      mstatus_reg.mpie <= mstatus_reg.mie;
      mstatus_reg.mie  <= 1'b0;
      mstatus_reg.mpp  <= (HAS_U && (cur_priv == PRIV_U)) ? PRIV_U : PRIV_M;
    end else if (mret_valid) begin
      mstatus_reg.mie  <= mstatus_reg.mpie;
      mstatus_reg.mpie <= 1'b1;
      mstatus_reg.mpp  <= MPP_DEFAULT;
    end else if (csr_we) begin
      case (csr_bus.csr_addr)
        CSR_MSTATUS: begin
          mstatus_reg.mie  <= nv[MSTATUS_MIE_BIT];
          mstatus_reg.mpie <= nv[MSTATUS_MPIE_BIT];
          if (mpp_legal(nv[MSTATUS_MPP_LSB +: 2])) begin
            mstatus_reg.mpp <= nv[MSTATUS_MPP_LSB +: 2];
          end
        end
        CSR_MIE:      mie_reg      <= nv & MIE_WMASK;
        CSR_MTVEC:    if (!nv[1]) mtvec_reg <= nv;
        CSR_MSCRATCH: mscratch_reg <= nv;
        CSR_MEPC:     mepc_reg     <= nv & ~32'h3;
        CSR_MCAUSE:   mcause_reg   <= nv;
        CSR_MTVAL:    mtval_reg    <= nv;
        default: ;
      endcase
    end
  end

  assign irq_pend = {irq_meip & mie_reg[IRQ_CODE_MEI],
                     irq_mtip & mie_reg[IRQ_CODE_MTI],
                     irq_msip & mie_reg[IRQ_CODE_MSI]};

  // Arbitration order is MEI, then MSI, then MTI.
  always_comb begin
    irq_code = 4'd0;
    if (irq_pend[2])      irq_code = IRQ_CODE_MEI;
    else if (irq_pend[0]) irq_code = IRQ_CODE_MSI;
    else if (irq_pend[1]) irq_code = IRQ_CODE_MTI;
  end

  assign irq_req   = (|irq_pend) && (mstatus_reg.mie || (cur_priv == PRIV_U));
  assign irq_cause = {1'b1, 27'b0, irq_code};

  assign trap_pc = {mtvec_reg[31:2], 2'b00} +
                   (((mtvec_reg[1:0] == 2'b01) && trap_cause[31]) ? {trap_cause[29:0], 2'b00} : 32'h0);

  assign mret_pc   = mepc_reg;
  assign mret_priv = mstatus_reg.mpp;
  assign ctrl_mie  = mstatus_reg.mie;
  assign ctrl_mpie = mstatus_reg.mpie;
  assign ctrl_mpp  = mstatus_reg.mpp;

endmodule
